// File: rtl/crumb_pkg.sv
// Shared types and defaults for the crumb chain collector.
// The parity option is controlled by CRUMB_COLLECT_PARITY_EN.
package crumb_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } crumb_state_e;
endpackage

// File: rtl/crumb_fifo.sv
// Synchronous show-ahead FIFO; the head reads as 0 while empty.
module crumb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  // A pop frees a slot in the same edge, so a full FIFO can still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/crumb_collector.sv
// Deserialises the chain's en-qualified bit stream (MSB first) into words and buffers them.
// Define CRUMB_COLLECT_PARITY_EN to expect one even-parity bit after every word.
module crumb_collector import crumb_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   rbit_i,
  output logic [WIDTH-1:0]       word_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   parity_err_o
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH-1);

  crumb_state_e     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic             last_bit, push_req, pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] push_word, sample_word;

  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign sample_word = {shreg_q[WIDTH-2:0], rbit_i};
  assign pop         = valid_o & ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DATA;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
    end
  end

  // Next state and deserialiser
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (en_i && state_q == S_DATA) begin
      shreg_d   = sample_word;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
`ifdef CRUMB_COLLECT_PARITY_EN
      if (last_bit) state_d = S_PAR;
    end else if (en_i && state_q == S_PAR) begin
      state_d = S_DATA;
`endif
    end
  end

  // Outputs: push request and sticky flags
  always_comb begin
    push_req  = 1'b0;
    push_word = sample_word;
    perr_d    = perr_q;
`ifdef CRUMB_COLLECT_PARITY_EN
    // shreg_q stops shifting in S_PAR, so it still holds the whole data word.
    if (en_i && state_q == S_PAR) begin
      push_word = shreg_q;
      if (^{shreg_q, rbit_i}) perr_d   = 1'b1;
      else                    push_req = 1'b1;
    end
`else
    push_req = en_i & (state_q == S_DATA) & last_bit;
`endif
    ovf_d = ovf_q | (push_req & fifo_full & ~pop);
  end

  crumb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  (push_word),
    .pop_i   (pop),
    .head_o  (word_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign valid_o      = ~fifo_empty;
  assign overflow_o   = ovf_q;
  assign parity_err_o = perr_q;
endmodule
